// File: rtl/comm_mem_responder.sv
// comm_mem_responder: memory server on one comm channel. It pops a request,
// executes it against a local 32-bit word RAM, and pushes exactly one reply.
// Only one request is in flight at a time, so replies come back in request order.
// Optional build macro COMM_MEM_RESPONDER_STATS_EN adds saturating request
// and error counters (stat_req_o / stat_err_o).
module comm_mem_responder #(
    parameter int MESSAGE_BIT = 72,
    parameter int ADDR_BIT    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   comm_readable_i,
    input  logic [MESSAGE_BIT-1:0] comm_r_data_i,
    input  logic [4:0]             comm_r_length_i,
    output logic                   comm_r_flag_o,
    input  logic                   comm_writable_i,
    output logic                   comm_w_flag_o,
    output logic [MESSAGE_BIT-1:0] comm_w_data_o,
    output logic [4:0]             comm_w_length_o
`ifdef COMM_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]            stat_req_o,
    output logic [15:0]            stat_err_o
`endif
);

    typedef enum logic [1:0] {IDLE, DECODE, READ, REPLY} state_e;

    state_e        state_q, state_d;
    logic [1:0]    rw_q, rw_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [4:0]    len_q, len_d;
    logic [31:0]   reply_word_q, reply_word_d;
    logic [4:0]    reply_len_q, reply_len_d;
    logic [31:0]   rdata_q;
    logic [31:0]   ram_q [2**ADDR_BIT];
    logic          ram_we;
    logic          req_valid;
    logic          err_evt;
    logic [ADDR_BIT-1:0] word_idx;

    // Command bits [3:2] carry no meaning in this protocol.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^comm_r_data_i[3:2];

    assign word_idx = addr_q[ADDR_BIT+1:2];

    // Request validation: legal rw/length pair, word aligned, inside the RAM.
    always_comb begin
        req_valid = 1'b0;
        if (((rw_q == 2'b01) && (len_q == 5'd5)) || ((rw_q == 2'b10) && (len_q == 5'd9))) begin
            req_valid = (addr_q[1:0] == 2'b00) && ((addr_q >> (ADDR_BIT + 2)) == 32'd0);
        end
    end

    // Next-state and handshake logic; r_flag and w_flag are single-cycle pops/pushes.
    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        mask_d        = mask_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        len_d         = len_q;
        reply_word_d  = reply_word_q;
        reply_len_d   = reply_len_q;
        comm_r_flag_o = 1'b0;
        comm_w_flag_o = 1'b0;
        ram_we        = 1'b0;
        err_evt       = 1'b0;
        case (state_q)
            IDLE: begin
                if (comm_readable_i) begin
                    comm_r_flag_o = 1'b1;
                    rw_d          = comm_r_data_i[1:0];
                    mask_d        = comm_r_data_i[7:4];
                    addr_d        = comm_r_data_i[39:8];
                    wdata_d       = comm_r_data_i[71:40];
                    len_d         = comm_r_length_i;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                if (!req_valid) begin
                    err_evt      = 1'b1;
                    reply_word_d = 32'h0000_00FF;
                    reply_len_d  = 5'd1;
                    state_d      = REPLY;
                end else if (rw_q == 2'b01) begin
                    state_d = READ;
                end else begin
                    ram_we       = 1'b1;
                    reply_word_d = 32'h0000_0000;
                    reply_len_d  = 5'd1;
                    state_d      = REPLY;
                end
            end
            READ: begin
                reply_word_d = rdata_q;
                reply_len_d  = 5'd4;
                state_d      = REPLY;
            end
            REPLY: begin
                if (comm_writable_i) begin
                    comm_w_flag_o = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and reply registers; a pending reply is discarded by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rw_q         <= 2'b00;
            mask_q       <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            len_q        <= 5'd0;
            reply_word_q <= 32'h0;
            reply_len_q  <= 5'd0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            mask_q       <= mask_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            len_q        <= len_d;
            reply_word_q <= reply_word_d;
            reply_len_q  <= reply_len_d;
        end
    end

    // Word RAM with byte-masked write and registered read; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mask_q[k]) begin
                    ram_q[word_idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
        rdata_q <= ram_q[word_idx];
    end

    assign comm_w_data_o   = {{(MESSAGE_BIT-32){1'b0}}, reply_word_q};
    assign comm_w_length_o = reply_len_q;

`ifdef COMM_MEM_RESPONDER_STATS_EN
    logic [15:0] req_cnt_q, req_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating event counters for pops and error replies.
    always_comb begin
        req_cnt_d = req_cnt_q;
        err_cnt_d = err_cnt_q;
        if (comm_r_flag_o && (req_cnt_q != 16'hFFFF)) req_cnt_d = req_cnt_q + 16'd1;
        if (err_evt && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_cnt_q <= 16'h0;
            err_cnt_q <= 16'h0;
        end else begin
            req_cnt_q <= req_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_req_o = req_cnt_q;
    assign stat_err_o = err_cnt_q;
`else
    logic unused_err_evt;
    assign unused_err_evt = err_evt;
`endif

endmodule
